// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle integer multiply / divide unit. Divide is a restoring
//            radix-2 shift-subtract taking WIDTH cycles. Multiply is either a
//            single-cycle combinational multiplier (default) or a WIDTH-cycle
//            shift-add sharing the divide registers (MULDIV_ITER_MULT_EN).
// Ports    : clk      - clock, rising edge
//            rst      - synchronous active-high reset
//            start    - begin an operation (sampled in IDLE only)
//            cancel   - abort the operation in flight
//            isdiv    - 1 = divide, 0 = multiply
//            signedop - 1 = two's-complement operands
//            a, b     - dividend/multiplicand, divisor/multiplier
//            result   - {hi, lo}: product, or {remainder, quotient}
//            ready    - one-cycle pulse when result becomes valid
//            busy     - high while MUL or DIV is in progress
// Macro    : MULDIV_ITER_MULT_EN - iterative shift-add multiply
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cancel,
  input  logic                 isdiv,
  input  logic                 signedop,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 busy
);

  localparam int c_CNT_W = $clog2(WIDTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_DIV  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  // The operation kind is carried by the state itself (MUL vs DIV), so no
  // separate isdiv register is kept.
  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_count;
  logic               r_signA;
  logic               r_signB;
  logic [WIDTH-1:0]   r_hi;     // partial remainder / product high half
  logic [WIDTH-1:0]   r_lo;     // dividend->quotient / multiplier->product low
  logic [WIDTH-1:0]   r_opB;    // divisor / multiplicand magnitude
  logic [2*WIDTH-1:0] r_result;

  // Operand magnitudes; signs are only meaningful in signed mode.
  logic             w_negA;
  logic             w_negB;
  logic [WIDTH-1:0] w_magA;
  logic [WIDTH-1:0] w_magB;

  assign w_negA = signedop & a[WIDTH-1];
  assign w_negB = signedop & b[WIDTH-1];
  assign w_magA = w_negA ? -a : a;
  assign w_magB = w_negB ? -b : b;

  // Restoring divide step. The shifted partial remainder needs one extra bit
  // because it can momentarily reach 2*divisor-1. When the subtraction is
  // taken the true difference is below the divisor, so the low WIDTH bits of
  // a modular subtract are exact. A zero divisor always subtracts, giving an
  // all-ones quotient and the dividend as the remainder.
  logic [WIDTH:0]     w_remShift;
  logic               w_canSub;
  logic [WIDTH-1:0]   w_remSub;
  logic [WIDTH-1:0]   w_divHi;
  logic [WIDTH-1:0]   w_divLo;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;
  logic [2*WIDTH-1:0] w_divResult;

  assign w_remShift  = {r_hi, r_lo[WIDTH-1]};
  assign w_canSub    = (w_remShift >= {1'b0, r_opB});
  assign w_remSub    = w_remShift[WIDTH-1:0] - r_opB;
  assign w_divHi     = w_canSub ? w_remSub : w_remShift[WIDTH-1:0];
  assign w_divLo     = {r_lo[WIDTH-2:0], w_canSub};
  assign w_quoFix    = (r_signA ^ r_signB) ? -w_divLo : w_divLo;
  assign w_remFix    = r_signA ? -w_divHi : w_divHi;
  assign w_divResult = {w_remFix, w_quoFix};

  logic [2*WIDTH-1:0] w_mulMag;
  logic [2*WIDTH-1:0] w_mulResult;

`ifdef MULDIV_ITER_MULT_EN
  // Shift-add: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift {carry, hi, lo} right by one. After
  // WIDTH steps {hi, lo} holds the full magnitude product.
  logic [WIDTH:0]   w_addSum;
  logic [WIDTH-1:0] w_mulHi;
  logic [WIDTH-1:0] w_mulLo;

  assign w_addSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opB} : {(WIDTH+1){1'b0}});
  assign w_mulHi  = w_addSum[WIDTH:1];
  assign w_mulLo  = {w_addSum[0], r_lo[WIDTH-1:1]};
  assign w_mulMag = {w_mulHi, w_mulLo};
`else
  assign w_mulMag = {{WIDTH{1'b0}}, r_lo} * {{WIDTH{1'b0}}, r_opB};
`endif

  assign w_mulResult = (r_signA ^ r_signB) ? -w_mulMag : w_mulMag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_count  <= '0;
      r_signA  <= 1'b0;
      r_signB  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opB    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          // cancel wins over a simultaneous start
          if (start && !cancel) begin
            r_signA <= w_negA;
            r_signB <= w_negB;
            r_hi    <= '0;
            r_lo    <= w_magA;
            r_opB   <= w_magB;
            r_count <= c_CNT_W'(WIDTH - 1);
            r_state <= isdiv ? c_DIV : c_MUL;
          end
        end
        c_MUL: begin
          if (cancel) begin
            r_state <= c_IDLE;
          end else begin
`ifdef MULDIV_ITER_MULT_EN
            r_hi    <= w_mulHi;
            r_lo    <= w_mulLo;
            r_count <= r_count - 1'b1;
            if (r_count == '0) begin
              r_result <= w_mulResult;
              r_state  <= c_DONE;
            end
`else
            r_result <= w_mulResult;
            r_state  <= c_DONE;
`endif
          end
        end
        c_DIV: begin
          if (cancel) begin
            r_state <= c_IDLE;
          end else begin
            r_hi    <= w_divHi;
            r_lo    <= w_divLo;
            r_count <= r_count - 1'b1;
            if (r_count == '0) begin
              r_result <= w_divResult;
              r_state  <= c_DONE;
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign result = r_result;
  assign ready  = (r_state == c_DONE);
  assign busy   = (r_state == c_MUL) || (r_state == c_DIV);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit (WIDTH=32). Expected results
//            come from plain 64-bit arithmetic; latencies from the operation
//            kind and the MULDIV_ITER_MULT_EN build option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int WIDTH   = 32;
  localparam int LAT_DIV = WIDTH + 1;
`ifdef MULDIV_ITER_MULT_EN
  localparam int LAT_MUL = WIDTH + 1;
`else
  localparam int LAT_MUL = 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              cancel = 1'b0;
  logic              isdiv = 1'b0;
  logic              signedop = 1'b0;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic [2*WIDTH-1:0] result;
  logic              ready;
  logic              busy;

  int nChecks = 0;
  int nFails  = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .isdiv(isdiv),
    .signedop(signedop), .a(a), .b(b), .result(result), .ready(ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: signed ops use exact 64-bit arithmetic, whose truncating
  // division gives a remainder carrying the dividend's sign.
  function automatic logic [63:0] refModel(bit d, bit s, logic [31:0] x, logic [31:0] y);
    longint sx, sy;
    logic [31:0] q;
    logic [31:0] m;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!d) begin
      if (s) r = 64'(sx * sy);
      else   r = {32'b0, x} * {32'b0, y};
    end else if (y == 32'd0) begin
      // All-ones quotient magnitude; zero divisor counts as positive, so the
      // quotient is negated only for a negative signed dividend.
      q = 32'hFFFF_FFFF;
      if (s && x[31]) q = 32'd1;
      r = {x, q};
    end else if (s) begin
      q = 32'(sx / sy);
      m = 32'(sx % sy);
      r = {m, q};
    end else begin
      r = {x % y, x / y};
    end
    return r;
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Runs one operation starting at the first idle cycle. Returns the result
  // seen with ready, the cycle ready appeared (0 = never), and a count of
  // protocol violations: busy wrong before/at ready, or result moving while
  // busy. Operands are scrambled right after the start edge.
  task automatic runOp(input bit d, input bit s, input logic [31:0] x, input logic [31:0] y,
                       output logic [63:0] res, output int rc, output int viol);
    logic [63:0] prev;
    rc = 0; viol = 0; res = '0;
    for (int i = 0; i < 200 && (busy !== 1'b0 || ready !== 1'b0); i++) begin
      @(posedge clk); #1;
    end
    isdiv = d; signedop = s; a = x; b = y; start = 1'b1;
    prev = result;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    isdiv = ~d; signedop = ~s;
    for (int c = 1; c <= 200; c++) begin
      if (ready === 1'b1) begin
        rc = c; res = result;
        if (busy !== 1'b0) viol++;
        break;
      end
      if (busy !== 1'b1) viol++;
      if (result !== prev) viol++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (result !== 64'd0) begin nFails++; $display("FAIL reset_result got=%h exp=0", result); end
    nChecks++; if (ready !== 1'b0) begin nFails++; $display("FAIL reset_ready got=%b exp=0", ready); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [63:0] res;
    int rc, viol;
    runOp(1'b1, 1'b0, 32'd100, 32'd7, res, rc, viol);
    nChecks++; if (res !== {32'd2, 32'd14}) begin nFails++; $display("FAIL div_100_7 got=%h exp=%h", res, {32'd2, 32'd14}); end
    nChecks++; if (rc !== 33) begin nFails++; $display("FAIL div_latency got=%0d exp=33", rc); end
    nChecks++; if (viol !== 0) begin nFails++; $display("FAIL div_busy_window violations=%0d exp=0", viol); end
    runOp(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, res, rc, viol);
    nChecks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin nFails++; $display("FAIL sdiv_m7_2 got=%h exp=ffffffff_fffffffd", res); end
    runOp(1'b1, 1'b0, 32'h1234_5678, 32'd0, res, rc, viol);
    nChecks++; if (res !== 64'h1234_5678_FFFF_FFFF) begin nFails++; $display("FAIL div_by_zero got=%h exp=12345678_ffffffff", res); end
    nChecks++; if (rc !== 33) begin nFails++; $display("FAIL div_by_zero_latency got=%0d exp=33", rc); end
    runOp(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, res, rc, viol);
    nChecks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF1) begin nFails++; $display("FAIL smul_m3_5 got=%h exp=ffffffff_fffffff1", res); end
    nChecks++; if (rc !== LAT_MUL) begin nFails++; $display("FAIL mul_latency got=%0d exp=%0d", rc, LAT_MUL); end
    nChecks++; if (viol !== 0) begin nFails++; $display("FAIL mul_busy_window violations=%0d exp=0", viol); end
  endtask

  // Back-to-back random ops: each start lands in the idle cycle right after
  // the previous DONE.
  task automatic test_random();
    logic [63:0] res, exp;
    logic [31:0] x, y;
    int rc, viol, lat;
    bit d, s;
    for (int n = 0; n < 40; n++) begin
      d = 1'($urandom); s = 1'($urandom);
      x = pickVal(); y = pickVal();
      exp = refModel(d, s, x, y);
      lat = d ? LAT_DIV : LAT_MUL;
      runOp(d, s, x, y, res, rc, viol);
      nChecks++; if (res !== exp) begin nFails++; $display("FAIL rand_result n=%0d div=%0b sgn=%0b a=%h b=%h got=%h exp=%h", n, d, s, x, y, res, exp); end
      nChecks++; if (rc !== lat) begin nFails++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, rc, lat); end
      nChecks++; if (viol !== 0) begin nFails++; $display("FAIL rand_protocol n=%0d violations=%0d exp=0", n, viol); end
      @(posedge clk); #1;
      nChecks++; if (ready !== 1'b0 || busy !== 1'b0) begin nFails++; $display("FAIL rand_ready_pulse n=%0d ready=%b busy=%b exp=0,0", n, ready, busy); end
    end
  endtask

  task automatic test_cancel();
    logic [63:0] prev, res;
    int rc, viol;
    bit sawReady;
    // Divide cancelled at cycle 10, restarted in the following idle cycle.
    prev = result; sawReady = 1'b0;
    isdiv = 1'b1; signedop = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) sawReady = 1'b1;
    end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    if (ready === 1'b1) sawReady = 1'b1;
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL cancel_div_busy got=%b exp=0", busy); end
    nChecks++; if (sawReady !== 1'b0) begin nFails++; $display("FAIL cancel_div_ready got=%b exp=0", sawReady); end
    nChecks++; if (result !== prev) begin nFails++; $display("FAIL cancel_div_result got=%h exp=%h", result, prev); end
    runOp(1'b1, 1'b0, 32'd500, 32'd7, res, rc, viol);
    nChecks++; if (res !== {32'd3, 32'd71}) begin nFails++; $display("FAIL cancel_restart got=%h exp=%h", res, {32'd3, 32'd71}); end
    nChecks++; if (rc !== 33) begin nFails++; $display("FAIL cancel_restart_latency got=%0d exp=33", rc); end
    // Multiply cancelled in its first busy cycle.
    @(posedge clk); #1;
    prev = result;
    isdiv = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    nChecks++; if (ready !== 1'b0 || busy !== 1'b0) begin nFails++; $display("FAIL cancel_mul ready=%b busy=%b exp=0,0", ready, busy); end
    nChecks++; if (result !== prev) begin nFails++; $display("FAIL cancel_mul_result got=%h exp=%h", result, prev); end
    // start together with cancel in IDLE: stays idle.
    start = 1'b1; cancel = 1'b1; isdiv = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL start_cancel_idle busy=%b exp=0", busy); end
    @(posedge clk); #1;
    nChecks++; if (ready !== 1'b0) begin nFails++; $display("FAIL start_cancel_idle_ready got=%b exp=0", ready); end
  endtask

  // Cancel during DONE: the pulse already shown and its result stand.
  task automatic test_cancel_in_done();
    logic [63:0] res;
    int rc, viol;
    runOp(1'b0, 1'b0, 32'd6, 32'd7, res, rc, viol);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    nChecks++; if (res !== 64'd42) begin nFails++; $display("FAIL done_cancel_value got=%h exp=2a", res); end
    nChecks++; if (result !== 64'd42) begin nFails++; $display("FAIL done_cancel_hold got=%h exp=2a", result); end
  endtask

  // Extra start at cycle 5 is ignored; reset at cycle 12 aborts the divide.
  task automatic test_start_then_reset();
    bit sawReady, notBusy;
    sawReady = 1'b0; notBusy = 1'b0;
    isdiv = 1'b1; signedop = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 12; c++) begin
      if (c == 5) begin start = 1'b1; isdiv = 1'b0; a = 32'd5; b = 32'd1; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (ready === 1'b1) sawReady = 1'b1;
      if (busy !== 1'b1) notBusy = 1'b1;
    end
    start = 1'b0;
    nChecks++; if (notBusy !== 1'b0) begin nFails++; $display("FAIL extra_start_busy dropped=%b exp=0", notBusy); end
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    if (ready === 1'b1) sawReady = 1'b1;
    nChecks++; if (result !== 64'd0) begin nFails++; $display("FAIL midop_reset_result got=%h exp=0", result); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL midop_reset_busy got=%b exp=0", busy); end
    repeat (40) begin
      @(posedge clk); #1;
      if (ready === 1'b1) sawReady = 1'b1;
    end
    nChecks++; if (sawReady !== 1'b0) begin nFails++; $display("FAIL midop_reset_ready got=%b exp=0", sawReady); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_cancel();
    test_cancel_in_done();
    test_start_then_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
